// File: rtl/arr_pkg.sv
// Shared constants, FSM state type and the per-lane requantizer for the array output drain.
// Define ARR_OUT_RELU_EN to clamp negative rounded values to zero before saturation.
package arr_pkg;
  localparam int unsigned LANES = 16;
  localparam int unsigned ACCW  = 20;
  localparam int unsigned OUTW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic signed [ACCW:0] SAT_HI = (ACCW+1)'(2**(OUTW-1) - 1);
  localparam logic signed [ACCW:0] SAT_LO = (ACCW+1)'(-(2**(OUTW-1)));

  // Round half up, arithmetic shift, then clamp to the signed output byte range.
  function automatic logic [OUTW-1:0] requant(input logic [ACCW-1:0] psum,
                                              input logic [4:0]      sh);
    logic signed [ACCW:0] half;
    logic signed [ACCW:0] sum;
    logic signed [ACCW:0] shr;
    half = '0;
    if (sh != '0) half = (ACCW+1)'(1) << (sh - 5'd1);
    sum = $signed({psum[ACCW-1], psum}) + half;
    shr = sum >>> sh;
`ifdef ARR_OUT_RELU_EN
    if (shr[ACCW]) shr = '0;
`endif
    if (shr > SAT_HI) shr = SAT_HI;
    else if (shr < SAT_LO) shr = SAT_LO;
    return shr[OUTW-1:0];
  endfunction
endpackage

// File: rtl/arr_deskew.sv
// Triangular delay line: lane i is delayed LANES-1-i cycles so that all lanes of one
// array result line up in the same cycle; the last lane passes straight through.
module arr_deskew #(
  parameter int unsigned LANES = 16,
  parameter int unsigned ACCW  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [LANES*ACCW-1:0] din,
  input  logic [LANES-1:0]      vin,
  output logic [LANES*ACCW-1:0] dout,
  output logic [LANES-1:0]      vout
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int unsigned DEPTH = LANES - 1 - i;
    if (DEPTH == 0) begin : g_pass
      assign dout[i*ACCW +: ACCW] = din[i*ACCW +: ACCW];
      assign vout[i]              = vin[i];
    end else begin : g_dly
      logic [ACCW:0] sr_q [DEPTH];
      logic [ACCW:0] sr_d [DEPTH];

      always_comb begin
        sr_d[0] = {vin[i], din[i*ACCW +: ACCW]};
        for (int unsigned k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst || flush) sr_q <= '{default: '0};
        else              sr_q <= sr_d;
      end

      assign {vout[i], dout[i*ACCW +: ACCW]} = sr_q[DEPTH-1];
    end
  end
endmodule

// File: rtl/arr_out_drain.sv
// Systolic array output drain: deskew, requantize, 2-vector FIFO, byte serializer.
// Optional ARR_OUT_RELU_EN (see arr_pkg) selects ReLU-clamped requantization.
module arr_out_drain
  import arr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            shift,
  input  logic [4:0]            n_lanes,
  input  logic [15:0]           num_vecs,
  input  logic [LANES*ACCW-1:0] psum_in,
  input  logic [LANES-1:0]      psum_valid,
  output logic [OUTW-1:0]       dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_skew,
  output logic                  err_ovf
);
  state_e                state_q, state_d;
  logic [4:0]            shift_q, shift_d;
  logic [4:0]            nl_q, nl_d;
  logic [15:0]           nv_q, nv_d;
  logic [15:0]           vcnt_q, vcnt_d;
  logic                  err_skew_q, err_skew_d;
  logic                  err_ovf_q, err_ovf_d;
  logic [LANES*OUTW-1:0] rq_q, rq_d;
  logic                  rq_vld_q, rq_vld_d;
  logic [LANES*OUTW-1:0] fifo_q [2];
  logic [LANES*OUTW-1:0] fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [3:0]            lane_q, lane_d;
  logic [OUTW-1:0]       dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic [LANES*ACCW-1:0] al_data;
  logic [LANES-1:0]      al_valid;
  logic                  fire, pop, wr_ok;

  arr_deskew #(.LANES(LANES), .ACCW(ACCW)) u_deskew (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .din   (psum_in),
    .vin   (psum_valid),
    .dout  (al_data),
    .vout  (al_valid)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    nl_d         = nl_q;
    nv_d         = nv_q;
    vcnt_d       = vcnt_q;
    err_skew_d   = err_skew_q;
    err_ovf_d    = err_ovf_q;
    rq_d         = rq_q;
    rq_vld_d     = 1'b0;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    fire         = 1'b0;
    pop          = 1'b0;
    wr_ok        = 1'b0;

    if (start) begin
      state_d      = ST_RUN;
      shift_d      = shift;
      nl_d         = n_lanes;
      nv_d         = num_vecs;
      vcnt_d       = '0;
      err_skew_d   = 1'b0;
      err_ovf_d    = 1'b0;
      rd_ptr_d     = 1'b0;
      wr_ptr_d     = 1'b0;
      cnt_d        = '0;
      lane_d       = '0;
      dout_valid_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (&al_valid) begin
        rq_vld_d = 1'b1;
        for (int unsigned l = 0; l < LANES; l++)
          rq_d[l*OUTW +: OUTW] = requant(al_data[l*ACCW +: ACCW], shift_q);
      end else if (|al_valid) begin
        err_skew_d = 1'b1;
      end

      // The head vector stays in the FIFO until its last byte is accepted, so the
      // next vector can be presented from the second entry without a bubble.
      fire = dout_valid_q && dout_ready;
      if (fire) begin
        if ({1'b0, lane_q} == nl_q - 5'd1) begin
          pop          = 1'b1;
          vcnt_d       = vcnt_q + 16'd1;
          lane_d       = '0;
          dout_valid_d = 1'b0;
          if (vcnt_d == nv_q) begin
            state_d = ST_DONE;
          end else if (cnt_q == 2'd2) begin
            dout_valid_d = 1'b1;
            dout_d       = fifo_q[~rd_ptr_q][0 +: OUTW];
          end
        end else begin
          lane_d = lane_q + 4'd1;
          dout_d = fifo_q[rd_ptr_q][lane_d*OUTW +: OUTW];
        end
      end else if (!dout_valid_q && cnt_q != '0) begin
        dout_valid_d = 1'b1;
        dout_d       = fifo_q[rd_ptr_q][0 +: OUTW];
        lane_d       = '0;
      end

      if (rq_vld_q) begin
        if (cnt_q == 2'd2 && !pop) begin
          err_ovf_d = 1'b1;
        end else begin
          wr_ok            = 1'b1;
          fifo_d[wr_ptr_q] = rq_q;
          wr_ptr_d         = ~wr_ptr_q;
        end
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, wr_ok} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      nl_q         <= '0;
      nv_q         <= '0;
      vcnt_q       <= '0;
      err_skew_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      rq_q         <= '0;
      rq_vld_q     <= 1'b0;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
      lane_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      nl_q         <= nl_d;
      nv_q         <= nv_d;
      vcnt_q       <= vcnt_d;
      err_skew_q   <= err_skew_d;
      err_ovf_q    <= err_ovf_d;
      rq_q         <= rq_d;
      rq_vld_q     <= rq_vld_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign err_skew   = err_skew_q;
  assign err_ovf    = err_ovf_q;
endmodule

// File: doc/arr_out_drain.md
# arr_out_drain

Output drain for the 16x16 systolic array: takes the skewed per-column partial sums the array emits on `saclk`-aligned cycles, deskews them into one aligned vector, requantizes each lane to 8 bits and streams the bytes out over a valid/ready port toward the output memory writer. It sits directly downstream of the array that the array controller feeds, and closes the compute loop: the controller issues windows, this block retires their results.

## Interface
- `LANES`, 16, number of array columns (output channels per pass)
- `ACCW`, 20, signed partial-sum width per lane
- `OUTW`, 8, signed output byte width
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  pulse; clears counters and error flags, arms a new pass
- `shift`  in  5  requant right-shift amount (0..ACCW-1), sampled on `start`
- `n_lanes`  in  5  valid output channels this pass (1..16), sampled on `start`
- `num_vecs`  in  16  vectors expected this pass (≥1), sampled on `start`
- `psum_in`  in  LANES*ACCW  lane i at bits [i*ACCW +: ACCW]
- `psum_valid`  in  LANES  per-lane valid; lane i presents result i cycles after lane 0
- `dout`  out  OUTW  output byte
- `dout_valid`  out  1  byte valid
- `dout_ready`  in  1  downstream accept
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `err_skew`  out  1  sticky: aligned lane valids disagreed
- `err_ovf`  out  1  sticky: aligned vector arrived with FIFO full, vector dropped

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DONE when `num_vecs` vectors fully emitted (last byte handshaked); DONE -> RUN on `start`. `start` in RUN restarts: flushes deskew, FIFO and serializer, reloads config.
- Deskew: lane i data+valid delayed LANES-1-i cycles; lane 15 undelayed. Aligned vector exists when all aligned valids are 1. If some but not all are 1: set `err_skew`, discard that cycle.
- Requant per lane: if shift>0 add 1<<(shift-1) (round half up) in ACCW+1 bits, arithmetic shift right by `shift`, saturate to [-128,127].
- FIFO: 2 vector entries. Write with FIFO full: drop, set `err_ovf` (array cannot stall). Simultaneous write and read on full is legal, no overflow.
- Serializer: pops one vector, emits lanes 0..n_lanes-1 in order, one byte per accepted handshake; lanes ≥ n_lanes never emitted. Vector counter increments on last byte of a vector.
- Aligned vectors arriving in IDLE or DONE are ignored, no error.
- Counters 16-bit; vector count does not wrap (DONE reached first).

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `err_skew`=0, `err_ovf`=0; FSM IDLE; FIFO empty; deskew regs cleared.
- Lane 0 valid sampled cycle t -> aligned at t+15 -> requant register t+16 -> FIFO write t+17 -> earliest `dout_valid` t+18.
- `dout`/`dout_valid` registered; held stable while `dout_valid` and not `dout_ready`.
- Zero-bubble: next byte (same or next vector) presented the cycle after acceptance if available.
- `done` rises the cycle after the last handshake; `busy` falls same cycle.
- `rst` mid-pass: all state to reset values next edge, in-flight data lost.

## Configuration
- `ARR_OUT_RELU_EN`: defined -> negative rounded values clamp to 0 before saturation (output range 0..127). Undefined -> signed saturation only.

## Structure
- Shared package `arr_pkg`: LANES, ACCW, OUTW defaults, FSM state enum (IDLE, RUN, DONE), requant/saturate function.
- Sub-module `arr_deskew`: triangular delay line, parameterized LANES/ACCW, outputs aligned data + valid vector.

## Test plan
- Basic: shift=4, n_lanes=16, num_vecs=1, lane i psum=16*i skewed -> bytes 0..15 in order, `done` one cycle after 16th handshake, first `dout_valid` at t+18.
- Rounding/saturation: shift=2, psums 5, 6, -6, 1000, -1000 -> 1, 2, -1, 127, -128 (RELU_EN: 1, 2, 0, 127, 0).
- Partial lanes: n_lanes=3, num_vecs=2 -> exactly 6 bytes, lanes 3..15 never appear.
- Backpressure: `dout_ready` low 40 cycles, 3 vectors 16 cycles apart -> third dropped, `err_ovf`=1, first two vectors intact.
- Skew error: lane 7 valid missing -> `err_skew`=1, no bytes for that vector; next `start` clears flag.
- Reset mid-pass: `rst` while byte 5 pending -> next cycle all outputs 0, FSM IDLE; fresh pass completes normally.
